// File: rtl/ifid_pkg.sv
// Shared types and constants for the IF/ID skid stage.
package ifid_pkg;

  // Occupancy of the two-slot stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Debug view of the stage internals.
  typedef struct packed {
    state_e state;
    logic   main_valid;
    logic   skid_valid;
  } dbg_t;

  // Default bubble instruction.
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifid_skid_stage_pipe_slot.sv
// One valid+payload register with synchronous clear and load.
module pipe_slot #(
  parameter int W = 64
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  // Clear wins over load so a flush cannot be undone by a same-cycle load.
  always_ff @(posedge clock) begin
    if (rst || clear) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end
  end

endmodule

// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage: valid/ready handshake, one-entry skid buffer,
// registered in_ready, flush to bubble and a saturating stall counter.
//
// Handshake: an entry transfers on a rising edge where valid and ready are
// both 1; a producer holding valid=1 keeps its payload stable until the
// transfer, and ready may be withdrawn at any time without a transfer.
module ifid_skid_stage
  import ifid_pkg::*;
#(
  parameter int                INST_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEFAULT),
  parameter int                CNT_W    = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [ADDR_W-1:0] in_pc4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc4,
  output logic [CNT_W-1:0]  stall_cnt,
  output dbg_t              dbg
);

  localparam int PW = INST_W + ADDR_W;

  state_e          state;
  state_e          state_nxt;
  logic            accept;
  logic            consume;
  logic            main_load;
  logic            main_clear;
  logic            main_sel_skid;
  logic            skid_load;
  logic            skid_clear;
  logic            main_valid;
  logic            skid_valid;
  logic [PW-1:0]   main_data;
  logic [PW-1:0]   skid_data;
  logic [PW-1:0]   main_din;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // State register.
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and slot controls; flush overrides everything below it.
  always_comb begin
    state_nxt     = state;
    main_load     = 1'b0;
    main_clear    = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          main_load = 1'b1;
        end
      end
      ONE: begin
        if (accept && consume) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_nxt = TWO;
          skid_load = 1'b1;
        end else if (consume) begin
          state_nxt  = EMPTY;
          main_clear = 1'b1;
        end
      end
      TWO: begin
        if (consume) begin
          state_nxt     = ONE;
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
          skid_clear    = 1'b1;
        end
      end
      default: begin
        state_nxt  = EMPTY;
        main_clear = 1'b1;
        skid_clear = 1'b1;
      end
    endcase
    if (flush) begin
      state_nxt  = EMPTY;
      main_load  = 1'b0;
      skid_load  = 1'b0;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end
  end

  // in_ready is a flop so fetch never sees a combinational path from decode.
  always_ff @(posedge clock) begin
    if (rst) begin
      in_ready <= 1'b1;
    end else begin
      in_ready <= (state_nxt != TWO);
    end
  end

  // Count back-pressured cycles, holding at all-ones.
  always_ff @(posedge clock) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign main_din = main_sel_skid ? skid_data : {in_inst, in_pc4};

  pipe_slot #(.W(PW)) u_main (
    .clock (clock),
    .rst   (rst),
    .clear (main_clear),
    .load  (main_load),
    .din   (main_din),
    .valid (main_valid),
    .dout  (main_data)
  );

  pipe_slot #(.W(PW)) u_skid (
    .clock (clock),
    .rst   (rst),
    .clear (skid_clear),
    .load  (skid_load),
    .din   ({in_inst, in_pc4}),
    .valid (skid_valid),
    .dout  (skid_data)
  );

  assign out_valid = main_valid;
  assign out_inst  = main_valid ? main_data[ADDR_W +: INST_W] : NOP_INST;
  assign out_pc4   = main_valid ? main_data[ADDR_W-1:0] : '0;

  assign dbg = '{state: state, main_valid: main_valid, skid_valid: skid_valid};

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Directed bench for ifid_skid_stage: reset, streaming, back-pressure,
// flush, counter saturation and reset+flush.
module tb_ifid_skid_stage;
  import ifid_pkg::*;

  logic        clock;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc4;
  logic [15:0] stall_cnt;
  dbg_t        dbg;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_inst;
  logic [31:0] s_out_pc4;
  logic [2:0]  s_stall_cnt;
  dbg_t        s_dbg;

  int tests_run;
  int tests_failed;

  // Clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  ifid_skid_stage dut (
    .clock     (clock),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc4    (in_pc4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc4   (out_pc4),
    .stall_cnt (stall_cnt),
    .dbg       (dbg)
  );

  ifid_skid_stage #(.CNT_W(3)) dut_small (
    .clock     (clock),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_inst   (in_inst),
    .in_pc4    (in_pc4),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_inst  (s_out_inst),
    .out_pc4   (s_out_pc4),
    .stall_cnt (s_stall_cnt),
    .dbg       (s_dbg)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] inst,
                           input logic [31:0] pc4);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_inst"}, out_inst, inst);
    check({tag, "_pc4"}, out_pc4, pc4);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc4    = '0;
    out_ready = 1'b0;

    // Reset then idle.
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_out("reset", 1'b0, 32'h0, 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_state", 32'(dbg.state), 32'(EMPTY));

    // Streaming: eight back-to-back entries with decode always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_inst  = 32'h100 + 32'(i);
      in_pc4   = 32'(4 * (i + 1));
      tick();
      check_out($sformatf("stream%0d", i), 1'b1, 32'h100 + 32'(i), 32'(4 * (i + 1)));
      check($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check_out("stream_drain", 1'b0, 32'h0, 32'h0);
    check("stream_stall_cnt", 32'(stall_cnt), 32'd0);

    // Back-pressure: A loads, B goes to skid, C is refused.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'hA0;
    in_pc4    = 32'h1000;
    tick();
    check_out("bp_a", 1'b1, 32'hA0, 32'h1000);
    check("bp_a_in_ready", 32'(in_ready), 32'd1);
    in_inst = 32'hB0;
    in_pc4  = 32'h1004;
    tick();
    check_out("bp_b_skid", 1'b1, 32'hA0, 32'h1000);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_state_two", 32'(dbg.state), 32'(TWO));
    check("bp_cnt1", 32'(stall_cnt), 32'd1);
    in_inst = 32'hC0;
    in_pc4  = 32'h1008;
    tick();
    tick();
    tick();
    check_out("bp_hold", 1'b1, 32'hA0, 32'h1000);
    check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    check("bp_cnt4", 32'(stall_cnt), 32'd4);
    out_ready = 1'b1;
    tick();
    check_out("bp_rel_b", 1'b1, 32'hB0, 32'h1004);
    check("bp_rel_in_ready", 32'(in_ready), 32'd1);
    tick();
    check_out("bp_rel_c", 1'b1, 32'hC0, 32'h1008);
    in_valid = 1'b0;
    tick();
    check_out("bp_drain", 1'b0, 32'h0, 32'h0);
    check("bp_cnt_after", 32'(stall_cnt), 32'd4);

    // Flush in TWO with input offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'hD0;
    in_pc4    = 32'h2000;
    tick();
    in_inst = 32'hE0;
    in_pc4  = 32'h2004;
    tick();
    check("fl_state_two", 32'(dbg.state), 32'(TWO));
    check("fl_pre_cnt", 32'(stall_cnt), 32'd5);
    flush   = 1'b1;
    in_inst = 32'hF0;
    in_pc4  = 32'h2008;
    tick();
    check_out("fl_two", 1'b0, 32'h0, 32'h0);
    check("fl_two_in_ready", 32'(in_ready), 32'd1);
    check("fl_two_cnt_kept", 32'(stall_cnt), 32'd6);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_out("fl_two_after", 1'b0, 32'h0, 32'h0);

    // Flush in ONE while an accept happens: the accepted entry is dropped.
    in_valid = 1'b1;
    in_inst  = 32'h110;
    in_pc4   = 32'h3000;
    tick();
    check_out("fl_one_pre", 1'b1, 32'h110, 32'h3000);
    flush   = 1'b1;
    in_inst = 32'h114;
    in_pc4  = 32'h3004;
    tick();
    check_out("fl_one", 1'b0, 32'h0, 32'h0);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check_out("fl_one_after", 1'b0, 32'h0, 32'h0);

    // Saturation of the 3-bit counter over 10 stalled cycles.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h120;
    in_pc4    = 32'h4000;
    tick();
    in_valid = 1'b0;
    check("sat_start", 32'(s_stall_cnt), 32'd0);
    for (int i = 0; i < 7; i++) tick();
    check("sat_at7", 32'(s_stall_cnt), 32'd7);
    for (int i = 0; i < 3; i++) tick();
    check("sat_hold", 32'(s_stall_cnt), 32'd7);
    check("sat_wide_cnt", 32'(stall_cnt), 32'd10);
    check("sat_small_out", s_out_inst, 32'h120);

    // Reset and flush together while in TWO.
    in_valid = 1'b1;
    in_inst  = 32'h130;
    in_pc4   = 32'h5000;
    tick();
    check("rf_state_two", 32'(dbg.state), 32'(TWO));
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    check_out("rf", 1'b0, 32'h0, 32'h0);
    check("rf_in_ready", 32'(in_ready), 32'd1);
    check("rf_stall_cnt", 32'(stall_cnt), 32'd0);
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check_out("rf_after", 1'b0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ifid_skid_stage.md
# ifid_skid_stage

Parametrised IF/ID pipeline stage with a valid/ready handshake and a one-entry skid buffer. It carries a fetched instruction word and its PC+4 from fetch to decode. It sustains one transfer per cycle under back-pressure and keeps in_ready registered. Flush squashes both entries to a bubble, and the block counts stall cycles for performance monitoring.

## Interface
Parameters:
- INST_W, 32, instruction width in bits
- ADDR_W, 32, PC width in bits
- NOP_INST, 32'h0000_0000, bubble value driven on out_inst when out_valid=0
- CNT_W, 16, width of the stall counter

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash all held entries this cycle
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  stage can accept; driven directly from a flop
- in_inst  in  INST_W  fetched instruction
- in_pc4  in  ADDR_W  PC+4 of that instruction
- out_valid  out  1  decode-side entry valid
- out_ready  in  1  decode accepts the entry
- out_inst  out  INST_W  instruction to decode
- out_pc4  out  ADDR_W  PC+4 to decode
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles

## Operation
- Storage is two slots:
  - main slot drives the outputs.
  - skid slot catches the entry accepted while the output stalls.
- Accept = in_valid & in_ready.
- Consume = out_valid & out_ready.
- States: EMPTY (no slot valid), ONE (main only), TWO (main+skid).
- EMPTY:
  - accept -> ONE, main loaded.
- ONE:
  - accept & consume -> ONE, main reloaded.
  - accept & !consume -> TWO, skid loaded.
  - !accept & consume -> EMPTY.
  - otherwise hold.
- TWO:
  - consume -> ONE, main <= skid.
  - Accept is impossible in TWO because in_ready=0.
- in_ready is the registered value of (next state != TWO).
- Entries leave in strict FIFO order. No entry is duplicated or dropped except by flush.
- When out_valid=0: out_inst = NOP_INST and out_pc4 = 0.
- flush=1:
  - next state EMPTY.
  - Any same-cycle accept is discarded.
  - Consume in that cycle is still counted as delivered.
- stall_cnt:
  - increments on every cycle with out_valid=1 & out_ready=0.
  - saturates at all-ones.
  - Flush does not clear it; only rst does.
- rst:
  - overrides flush and all other inputs.
  - Clears state and counter on the next edge.

## Timing
- Reset values: out_valid=0, out_inst=NOP_INST, out_pc4=0, in_ready=1, stall_cnt=0.
- Latency: entry accepted at edge N appears on the outputs after edge N (one cycle), when the stage was EMPTY or consumed the same cycle.
- Throughput: one entry per cycle while out_ready=1.
- Back-pressure:
  - First stalled cycle: one extra entry is absorbed into skid.
  - From the following cycle: in_ready=0.
  - After the first consume: in_ready returns to 1 one cycle later.
- Flush: takes effect at the next edge. After it, out_valid=0 and in_ready=1.
- rst mid-operation: same observable result as flush, plus stall_cnt=0.
- out_inst and out_pc4 are stable while out_valid=1 & out_ready=0.

## Structure
- Shared package ifid_pkg:
  - state enum {EMPTY, ONE, TWO}.
  - default NOP_INST constant.
- Sub-module pipe_slot:
  - one valid+payload register with load and clear.
  - instantiated twice, for main and skid.
- The counter and state logic live in the top module.

## Test plan
- Reset then idle: after rst, out_valid=0, out_inst=0, in_ready=1, stall_cnt=0.
- Streaming: 8 back-to-back entries (inst 0x100..0x107, pc4 0x4..0x20) with out_ready=1 -> identical sequence at the output one cycle later, no gaps.
- Back-pressure:
  - Setup: out_ready=0 for 5 cycles while in_valid=1 with inst A, B, C.
  - Required: A holds on the output; B sits in skid; in_ready=0 from cycle 3; C is not accepted; stall_cnt=4.
  - On release, the output shows A, B, C in order.
- Flush in state TWO with concurrent in_valid=1 -> out_valid=0 next cycle, the input is dropped, and in_ready=1.
- Saturation: with CNT_W=3, stall 10 cycles -> stall_cnt stays at 7.
- Reset and flush together: assert rst and flush together while in state TWO -> every output equals its reset value after one edge.
